// File: rtl/ahbl_apb_bridge_mux_if.sv
// AHB-Lite slave / APB3 multi-slot bus bundle for ahbl_apb_bridge_mux.
// The slave modport is the bridge's view; the master modport is the fabric plus APB slots.
interface ahbl_apb_bridge_mux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 16,
  parameter int APB_AW     = 12
);
  logic                             HSEL;
  logic [31:0]                      HADDR;
  logic                             HWRITE;
  logic [1:0]                       HTRANS;
  logic [DATA_WIDTH-1:0]            HWDATA;
  logic                             HREADYIN;
  logic                             HREADYOUT;
  logic                             HRESP;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic [APB_AW-1:0]                PADDR;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;
  logic                             TIMEOUT_ERR;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA,
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output TIMEOUT_ERR
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA,
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  TIMEOUT_ERR
  );
endinterface

// File: rtl/ahbl_apb_bridge_mux.sv
// AHB-Lite slave to multi-slot APB3 master bridge with per-slot response muxing
// and a PREADY timeout that converts a hung access into an AHB ERROR response.
module ahbl_apb_bridge_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 16,
  parameter int SLOT_LSB   = 12,
  parameter int APB_AW     = 12,
  parameter int TIMEOUT    = 256
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahbl_apb_bridge_mux_if.slave bus
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [31:0]   NUM_SLAVES_W = 32'(NUM_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;

  logic [SW-1:0]           slot_r;
  logic                    hwrite_r;
  logic [APB_AW-1:0]       addr_r;
  logic [CW-1:0]           cnt_r;

  logic                    hreadyout_r;
  logic                    hresp_r;
  logic [DATA_WIDTH-1:0]   hrdata_r;
  logic [NUM_SLAVES-1:0]   psel_r;
  logic [APB_AW-1:0]       paddr_r;
  logic                    penable_r;
  logic                    pwrite_r;
  logic [DATA_WIDTH-1:0]   pwdata_r;
  logic                    timeout_err_r;

  logic                    sample_s;
  logic                    accept_s;
  logic [SW-1:0]           slot_in_s;
  logic                    in_range_s;
  logic                    timeout_hit_s;
  logic [NUM_SLAVES-1:0]   psel_dec_s;
  logic [DATA_WIDTH-1:0]   prdata_sel_s;
  logic                    pready_sel_s;
  logic                    pslverr_sel_s;
  logic                    unused_s;

  // New address phases are only looked at while the bridge is ready.
  assign sample_s      = (state_r == ST_IDLE) || (state_r == ST_ERR2);
  assign accept_s      = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
  assign slot_in_s     = bus.HADDR[SLOT_LSB +: SW];
  assign in_range_s    = (32'(slot_in_s) < NUM_SLAVES_W);
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

  assign unused_s = ^{bus.HADDR, bus.HTRANS};

  // Decode the latched slot and mux that slot's response back.
  always_comb begin
    psel_dec_s    = '0;
    prdata_sel_s  = '0;
    pready_sel_s  = 1'b0;
    pslverr_sel_s = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      psel_dec_s[k] = (32'(slot_r) == 32'(k));
      prdata_sel_s  = prdata_sel_s
                    | (bus.PRDATA[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{psel_dec_s[k]}});
      pready_sel_s  = pready_sel_s  | (bus.PREADY[k]  & psel_dec_s[k]);
      pslverr_sel_s = pslverr_sel_s | (bus.PSLVERR[k] & psel_dec_s[k]);
    end
  end

  // Bridge state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          if (in_range_s) begin
            state_nxt_s = ST_LATCH;
          end else begin
            state_nxt_s = ST_ERR1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LATCH:  state_nxt_s = ST_SETUP;
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_sel_s) begin
          if (pslverr_sel_s) begin
            state_nxt_s = ST_ERR1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_ERR1;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_ERR1:   state_nxt_s = ST_ERR2;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Transfer context: address phase capture, APB address/data hold, wait counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      slot_r   <= '0;
      hwrite_r <= 1'b0;
      addr_r   <= '0;
      cnt_r    <= '0;
      paddr_r  <= '0;
      pwrite_r <= 1'b0;
      pwdata_r <= '0;
    end else begin
      if (sample_s && accept_s) begin
        slot_r   <= slot_in_s;
        hwrite_r <= bus.HWRITE;
        addr_r   <= bus.HADDR[APB_AW-1:0];
      end
      // LATCH is the AHB data phase, so HWDATA is valid here.
      if (state_r == ST_LATCH) begin
        paddr_r  <= addr_r;
        pwrite_r <= hwrite_r;
        cnt_r    <= '0;
        if (hwrite_r) begin
          pwdata_r <= bus.HWDATA;
        end
      end else if ((state_r == ST_ACCESS) && !pready_sel_s) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Registered bus outputs derived from the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hreadyout_r   <= 1'b1;
      hresp_r       <= 1'b0;
      hrdata_r      <= '0;
      psel_r        <= '0;
      penable_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      hreadyout_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ERR2);
      hresp_r       <= (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
      penable_r     <= (state_nxt_s == ST_ACCESS);
      psel_r        <= ((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS)) ? psel_dec_s : '0;
      timeout_err_r <= (state_r == ST_ACCESS) && !pready_sel_s && timeout_hit_s;
      if ((state_r == ST_ACCESS) && pready_sel_s && !pslverr_sel_s && !hwrite_r) begin
        hrdata_r <= prdata_sel_s;
      end
    end
  end

  assign bus.HREADYOUT   = hreadyout_r;
  assign bus.HRESP       = hresp_r;
  assign bus.HRDATA      = hrdata_r;
  assign bus.PSEL        = psel_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.TIMEOUT_ERR = timeout_err_r;

endmodule

// File: tb/tb_ahbl_apb_bridge_mux.sv
// Directed bench for ahbl_apb_bridge_mux: a default 16-slot instance and a
// 5-slot instance with TIMEOUT=4 share one clock and reset.
module tb_ahbl_apb_bridge_mux;

  logic hclk = 1'b0;
  logic hreset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 hclk = ~hclk;

  ahbl_apb_bridge_mux_if bus_a ();
  ahbl_apb_bridge_mux_if #(.DATA_WIDTH(32), .NUM_SLAVES(5), .APB_AW(12)) bus_b ();

  ahbl_apb_bridge_mux u_dut_a (
    .HCLK   (hclk),
    .HRESET (hreset),
    .bus    (bus_a)
  );

  ahbl_apb_bridge_mux #(.NUM_SLAVES(5), .TIMEOUT(4)) u_dut_b (
    .HCLK   (hclk),
    .HRESET (hreset),
    .bus    (bus_b)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hclk);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.HSEL   = 1'b0;
    bus_a.HTRANS = 2'b00;
    bus_a.HWRITE = 1'b0;
    bus_a.HADDR  = 32'h0;
  endtask

  task automatic idle_b();
    bus_b.HSEL   = 1'b0;
    bus_b.HTRANS = 2'b00;
    bus_b.HWRITE = 1'b0;
    bus_b.HADDR  = 32'h0;
  endtask

  task automatic addr_a(input logic [31:0] a, input logic w);
    bus_a.HSEL   = 1'b1;
    bus_a.HADDR  = a;
    bus_a.HWRITE = w;
    bus_a.HTRANS = 2'b10;
  endtask

  task automatic addr_b(input logic [31:0] a, input logic w);
    bus_b.HSEL   = 1'b1;
    bus_b.HADDR  = a;
    bus_b.HWRITE = w;
    bus_b.HTRANS = 2'b10;
  endtask

  initial begin
    hreset = 1'b1;
    idle_a();
    idle_b();
    bus_a.HREADYIN = 1'b1;
    bus_b.HREADYIN = 1'b1;
    bus_a.HWDATA   = 32'h0;
    bus_b.HWDATA   = 32'h0;
    bus_a.PREADY   = 16'hFFFF;
    bus_a.PSLVERR  = 16'h0000;
    bus_b.PREADY   = 5'b00000;
    bus_b.PSLVERR  = 5'b00000;
    for (int k = 0; k < 16; k++) bus_a.PRDATA[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
    for (int k = 0; k < 5; k++)  bus_b.PRDATA[k*32 +: 32] = 32'h5B5B_0000 + 32'(k);

    // Reset values
    cyc(2);
    chk("rst_hreadyout",   64'(bus_a.HREADYOUT),   64'h1);
    chk("rst_hresp",       64'(bus_a.HRESP),       64'h0);
    chk("rst_hrdata",      64'(bus_a.HRDATA),      64'h0);
    chk("rst_psel",        64'(bus_a.PSEL),        64'h0);
    chk("rst_penable",     64'(bus_a.PENABLE),     64'h0);
    chk("rst_paddr",       64'(bus_a.PADDR),       64'h0);
    chk("rst_pwrite",      64'(bus_a.PWRITE),      64'h0);
    chk("rst_pwdata",      64'(bus_a.PWDATA),      64'h0);
    chk("rst_timeout_err", 64'(bus_a.TIMEOUT_ERR), 64'h0);
    chk("rst_b_hreadyout", 64'(bus_b.HREADYOUT),   64'h1);
    hreset = 1'b0;

    // Read slot 3, zero-wait APB slave
    addr_a(32'h0000_3000, 1'b0);
    cyc(1);
    idle_a();
    chk("rd3_c1_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    chk("rd3_c1_psel",      64'(bus_a.PSEL),      64'h0);
    cyc(1);
    chk("rd3_c2_psel",      64'(bus_a.PSEL),      64'h0008);
    chk("rd3_c2_penable",   64'(bus_a.PENABLE),   64'h0);
    chk("rd3_c2_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    cyc(1);
    chk("rd3_c3_psel",      64'(bus_a.PSEL),      64'h0008);
    chk("rd3_c3_penable",   64'(bus_a.PENABLE),   64'h1);
    chk("rd3_c3_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    cyc(1);
    chk("rd3_c4_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("rd3_c4_hrdata",    64'(bus_a.HRDATA),    64'hA5A5_0003);
    chk("rd3_c4_hresp",     64'(bus_a.HRESP),     64'h0);
    chk("rd3_c4_psel",      64'(bus_a.PSEL),      64'h0);
    chk("rd3_c4_penable",   64'(bus_a.PENABLE),   64'h0);

    // Write to slot 5 with four PREADY-low cycles
    bus_a.PREADY[5] = 1'b0;
    addr_a(32'h0000_5010, 1'b1);
    cyc(1);
    idle_a();
    bus_a.HWDATA = 32'hDEAD_BEEF;
    chk("wr5_c1_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    cyc(1);
    chk("wr5_c2_psel",      64'(bus_a.PSEL),      64'h0020);
    chk("wr5_c2_penable",   64'(bus_a.PENABLE),   64'h0);
    chk("wr5_c2_paddr",     64'(bus_a.PADDR),     64'h010);
    chk("wr5_c2_pwrite",    64'(bus_a.PWRITE),    64'h1);
    chk("wr5_c2_pwdata",    64'(bus_a.PWDATA),    64'hDEAD_BEEF);
    bus_a.HWDATA = 32'h1234_5678;
    cyc(1);
    for (int i = 3; i <= 7; i++) begin
      chk("wr5_acc_penable",   64'(bus_a.PENABLE),   64'h1);
      chk("wr5_acc_psel",      64'(bus_a.PSEL),      64'h0020);
      chk("wr5_acc_pwdata",    64'(bus_a.PWDATA),    64'hDEAD_BEEF);
      chk("wr5_acc_paddr",     64'(bus_a.PADDR),     64'h010);
      chk("wr5_acc_pwrite",    64'(bus_a.PWRITE),    64'h1);
      chk("wr5_acc_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
      if (i == 7) bus_a.PREADY[5] = 1'b1;
      cyc(1);
    end
    chk("wr5_c8_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("wr5_c8_hresp",     64'(bus_a.HRESP),     64'h0);
    chk("wr5_c8_psel",      64'(bus_a.PSEL),      64'h0);
    chk("wr5_c8_hrdata",    64'(bus_a.HRDATA),    64'hA5A5_0003);
    chk("wr5_c8_pwdata",    64'(bus_a.PWDATA),    64'hDEAD_BEEF);
    chk("wr5_c8_paddr",     64'(bus_a.PADDR),     64'h010);

    // Slot 2 PSLVERR, then back-to-back read of slot 1 accepted in ERR2
    bus_a.PSLVERR[2] = 1'b1;
    addr_a(32'h0000_2004, 1'b0);
    cyc(1);
    idle_a();
    cyc(2);
    chk("err2_c3_penable",   64'(bus_a.PENABLE),   64'h1);
    chk("err2_c3_psel",      64'(bus_a.PSEL),      64'h0004);
    cyc(1);
    chk("err2_c4_hresp",     64'(bus_a.HRESP),     64'h1);
    chk("err2_c4_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    chk("err2_c4_psel",      64'(bus_a.PSEL),      64'h0);
    chk("err2_c4_penable",   64'(bus_a.PENABLE),   64'h0);
    cyc(1);
    chk("err2_c5_hresp",     64'(bus_a.HRESP),     64'h1);
    chk("err2_c5_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("err2_c5_hrdata",    64'(bus_a.HRDATA),    64'hA5A5_0003);
    addr_a(32'h0000_1000, 1'b0);
    bus_a.PSLVERR[2] = 1'b0;
    cyc(1);
    idle_a();
    chk("b2b_c6_hreadyout",  64'(bus_a.HREADYOUT), 64'h0);
    chk("b2b_c6_hresp",      64'(bus_a.HRESP),     64'h0);
    chk("b2b_c6_psel",       64'(bus_a.PSEL),      64'h0);
    cyc(1);
    chk("b2b_c7_psel",       64'(bus_a.PSEL),      64'h0002);
    cyc(1);
    chk("b2b_c8_penable",    64'(bus_a.PENABLE),   64'h1);
    cyc(1);
    chk("b2b_c9_hreadyout",  64'(bus_a.HREADYOUT), 64'h1);
    chk("b2b_c9_hrdata",     64'(bus_a.HRDATA),    64'hA5A5_0001);
    chk("b2b_c9_hresp",      64'(bus_a.HRESP),     64'h0);

    // BUSY, IDLE and unselected NONSEQ are all ignored
    bus_a.HSEL   = 1'b1;
    bus_a.HADDR  = 32'h0000_3000;
    bus_a.HTRANS = 2'b01;
    cyc(1);
    chk("busy_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("busy_hresp",     64'(bus_a.HRESP),     64'h0);
    bus_a.HTRANS = 2'b00;
    cyc(1);
    chk("idle_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("idle_psel",      64'(bus_a.PSEL),      64'h0);
    bus_a.HSEL   = 1'b0;
    bus_a.HTRANS = 2'b10;
    cyc(1);
    chk("nosel_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    cyc(1);
    chk("nosel_psel",      64'(bus_a.PSEL),      64'h0);
    idle_a();

    // TIMEOUT=4 with PREADY held low on slot 1
    addr_b(32'h0000_1000, 1'b0);
    cyc(1);
    idle_b();
    cyc(1);
    chk("to_c2_psel", 64'(bus_b.PSEL), 64'h02);
    cyc(1);
    for (int i = 3; i <= 6; i++) begin
      chk("to_acc_penable",     64'(bus_b.PENABLE),     64'h1);
      chk("to_acc_psel",        64'(bus_b.PSEL),        64'h02);
      chk("to_acc_timeout_err", 64'(bus_b.TIMEOUT_ERR), 64'h0);
      chk("to_acc_hreadyout",   64'(bus_b.HREADYOUT),   64'h0);
      cyc(1);
    end
    chk("to_c7_timeout_err", 64'(bus_b.TIMEOUT_ERR), 64'h1);
    chk("to_c7_psel",        64'(bus_b.PSEL),        64'h0);
    chk("to_c7_penable",     64'(bus_b.PENABLE),     64'h0);
    chk("to_c7_hresp",       64'(bus_b.HRESP),       64'h1);
    chk("to_c7_hreadyout",   64'(bus_b.HREADYOUT),   64'h0);
    cyc(1);
    chk("to_c8_timeout_err", 64'(bus_b.TIMEOUT_ERR), 64'h0);
    chk("to_c8_hresp",       64'(bus_b.HRESP),       64'h1);
    chk("to_c8_hreadyout",   64'(bus_b.HREADYOUT),   64'h1);
    cyc(1);
    chk("to_c9_hresp",       64'(bus_b.HRESP),       64'h0);
    chk("to_c9_hreadyout",   64'(bus_b.HREADYOUT),   64'h1);

    // Slot 6 does not exist on the 5-slot instance
    addr_b(32'h0000_6000, 1'b0);
    cyc(1);
    idle_b();
    chk("oor_c1_hresp",     64'(bus_b.HRESP),     64'h1);
    chk("oor_c1_hreadyout", 64'(bus_b.HREADYOUT), 64'h0);
    chk("oor_c1_psel",      64'(bus_b.PSEL),      64'h0);
    cyc(1);
    chk("oor_c2_hresp",     64'(bus_b.HRESP),     64'h1);
    chk("oor_c2_hreadyout", 64'(bus_b.HREADYOUT), 64'h1);
    chk("oor_c2_psel",      64'(bus_b.PSEL),      64'h0);
    cyc(1);
    chk("oor_c3_hresp",     64'(bus_b.HRESP),     64'h0);
    chk("oor_c3_psel",      64'(bus_b.PSEL),      64'h0);
    chk("oor_c3_penable",   64'(bus_b.PENABLE),   64'h0);

    // Reset during ACCESS, then a normal read
    bus_a.PREADY[4] = 1'b0;
    addr_a(32'h0000_4000, 1'b0);
    cyc(1);
    idle_a();
    cyc(2);
    chk("rsta_c3_penable", 64'(bus_a.PENABLE), 64'h1);
    chk("rsta_c3_psel",    64'(bus_a.PSEL),    64'h0010);
    hreset = 1'b1;
    cyc(1);
    chk("rsta_psel",      64'(bus_a.PSEL),      64'h0);
    chk("rsta_penable",   64'(bus_a.PENABLE),   64'h0);
    chk("rsta_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("rsta_hrdata",    64'(bus_a.HRDATA),    64'h0);
    chk("rsta_hresp",     64'(bus_a.HRESP),     64'h0);
    hreset = 1'b0;
    bus_a.PREADY[4] = 1'b1;
    addr_a(32'h0000_4000, 1'b0);
    cyc(1);
    idle_a();
    chk("post_c1_hreadyout", 64'(bus_a.HREADYOUT), 64'h0);
    cyc(3);
    chk("post_c4_hreadyout", 64'(bus_a.HREADYOUT), 64'h1);
    chk("post_c4_hrdata",    64'(bus_a.HRDATA),    64'hA5A5_0004);
    chk("post_c4_hresp",     64'(bus_a.HRESP),     64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
